fifo_rd_drain: RTL and testbench

FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

---
 rtl/fifo_rd_drain.sv | 108 ++++++++++
 tb/tb_fifo_rd_drain.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// Drains a FIFO read port (one-cycle read latency) into a valid/ready stream
// through a 2-entry skid buffer, tagging burst boundaries and counting beats.
module fifo_rd_drain #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              read_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              empty,
  output logic              read_en,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [15:0]       beat_total,
  output logic              idle
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e              occ_q, occ_d;
  logic              inflight_q;
  logic              run_q;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [15:0]       total_q, total_d;
  logic              last_q, last_d;
  logic              pop;
  logic [1:0]        level;

  assign m_valid    = (occ_q != EMPTY);
  assign m_data     = head_q;
  assign m_last     = last_q;
  assign beat_total = total_q;
  assign idle       = (occ_q == EMPTY) && !inflight_q;

  assign pop   = m_valid & m_ready;
  // Words owned after this edge: buffered plus the one landing now, minus the one leaving.
  assign level = 2'(occ_q) + 2'(inflight_q) - 2'(pop);

  // run_q holds reads off until the first clock edge after reset release.
  assign read_en = run_q & enable & ~empty & (level < 2'd2);

  always_comb begin
    occ_d  = occ_e'(level);
    head_d = head_q;
    tail_d = tail_q;
    case ({inflight_q, pop})
      2'b01: head_d = tail_q;
      2'b10: begin
        if (occ_q == EMPTY) head_d = data_out;
        else                tail_d = data_out;
      end
      2'b11: begin
        if (occ_q == ONE) head_d = data_out;
        else begin
          head_d = tail_q;
          tail_d = data_out;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    total_d = total_q;
    if (pop) begin
      bcnt_d  = (bcnt_q == LAST_IDX) ? '0 : bcnt_q + 1'b1;
      total_d = total_q + 16'd1;
    end
    // m_last is registered alongside the head it describes.
    last_d = (occ_d != EMPTY) && (bcnt_d == LAST_IDX);
  end

  always_ff @(posedge read_clk or negedge reset) begin
    if (!reset) begin
      occ_q      <= EMPTY;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      bcnt_q     <= '0;
      total_q    <= '0;
      last_q     <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= read_en;
      run_q      <= 1'b1;
      head_q     <= head_d;
      tail_q     <= tail_d;
      bcnt_q     <= bcnt_d;
      total_q    <= total_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Randomized and directed bench for fifo_rd_drain against a queue-level
// model of words owned by the drain block (fetched, not yet transferred).
module tb_fifo_rd_drain;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          read_clk = 1'b0;
  logic          reset    = 1'b0;
  logic          enable   = 1'b0;
  logic          empty    = 1'b1;
  logic          m_ready  = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic          read_en, m_valid, m_last, idle;
  logic [DW-1:0] m_data;
  logic [15:0]   beat_total;

  fifo_rd_drain #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .read_clk(read_clk), .reset(reset), .enable(enable), .empty(empty),
    .read_en(read_en), .data_out(data_out), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .beat_total(beat_total), .idle(idle)
  );

  always #5 read_clk = ~read_clk;

  int checks = 0;
  int errors = 0;

  // Model: source FIFO contents, and words popped but not yet transferred (oldest first).
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] pend[$];
  bit            infl;
  bit            run;
  bit            force_empty;
  int            bcnt;
  int unsigned   total;
  bit            smp_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    infl  = 1'b0;
    run   = 1'b0;
    bcnt  = 0;
    total = 0;
  endtask

  // Called at a falling edge with inputs already set; checks, then advances one clock.
  task automatic step();
    bit ev, pop, rd;
    int nbuf;
    logic [DW-1:0] w;
    empty = force_empty || (fifo.size() == 0);
    #1;
    nbuf = pend.size() - int'(infl);
    ev   = (nbuf > 0);
    pop  = ev && m_ready;
    rd   = reset && run && enable && !empty && ((pend.size() - int'(pop)) < 2);
    smp_valid = m_valid;
    check("read_en", {31'b0, read_en}, {31'b0, rd});
    check("m_valid", {31'b0, m_valid}, {31'b0, ev});
    check("m_last", {31'b0, m_last}, {31'b0, ev && (bcnt == BL - 1)});
    check("beat_total", {16'b0, beat_total}, {16'b0, total[15:0]});
    check("idle", {31'b0, idle}, {31'b0, pend.size() == 0});
    check("owned_le2", pend.size(), (pend.size() <= 2) ? pend.size() : 2);
    if (ev) check("m_data", {24'b0, m_data}, {24'b0, pend[0]});
    if (!reset) check("m_data_rst", {24'b0, m_data}, 32'd0);
    w = '0;
    @(posedge read_clk);
    if (reset) begin
      if (pop) begin
        void'(pend.pop_front());
        bcnt  = (bcnt + 1) % BL;
        total = total + 1;
      end
      if (rd) begin
        w = fifo.pop_front();
        pend.push_back(w);
      end
      infl = rd;
      run  = 1'b1;
    end
    #1;
    if (rd) data_out = w;
    @(negedge read_clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    step();
    step();
    reset = 1'b1;
    step();  // no read may issue before the first edge after release
  endtask

  task automatic drain(input int maxc, input bit need_fifo_empty);
    int n = 0;
    while ((pend.size() > 0 || (need_fifo_empty && fifo.size() > 0)) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int first_v;
    @(negedge read_clk);

    // Reset state and 17-word preload at full rate.
    for (int i = 1; i <= 17; i++) fifo.push_back(DW'(i));
    enable = 1'b1; m_ready = 1'b1; force_empty = 1'b0;
    do_reset();
    first_v = -1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (smp_valid && first_v < 0) first_v = c;
    end
    check("startup_latency", first_v, 32'd2);
    check("total_17", {16'b0, beat_total}, 32'd17);
    check("idle_17", {31'b0, idle}, 32'd1);

    // Toggling sink backpressure.
    enable = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) fifo.push_back(DW'($urandom));
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      m_ready = c[0] ? 1'b0 : 1'b1;
      step();
    end
    drain(20, 1'b1);
    check("total_toggle", {16'b0, beat_total}, 32'd8);

    // FIFO runs dry mid-burst, refills 5 cycles later.
    m_ready = 1'b1;
    enable  = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) fifo.push_back(DW'(8'hA0 + i));
    enable = 1'b1;
    for (int c = 0; c < 8; c++) step();
    for (int i = 0; i < 5; i++) fifo.push_back(DW'(8'hB0 + i));
    drain(30, 1'b1);
    check("total_gap", {16'b0, beat_total}, 32'd8);

    // enable drops right after the first read with the sink stalled.
    enable = 1'b0; m_ready = 1'b0;
    do_reset();
    fifo.delete();
    for (int i = 0; i < 6; i++) fifo.push_back(DW'(8'hC0 + i));
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int c = 0; c < 4; c++) step();
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    check("total_enable_drop", {16'b0, beat_total}, 32'd1);
    check("fifo_left", fifo.size(), 32'd5);

    // Randomized enable / ready / empty / refill.
    fifo.delete();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      enable      = ($urandom_range(0, 3) != 0);
      m_ready     = ($urandom_range(0, 2) != 0);
      force_empty = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) fifo.push_back(DW'($urandom));
      step();
    end
    enable = 1'b1; m_ready = 1'b1; force_empty = 1'b0;
    drain(600, 1'b1);

    // Asynchronous reset with two words buffered mid-burst.
    enable = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) fifo.push_back(DW'(8'hD0 + i));
    enable = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    m_ready = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("pre_reset_owned", pend.size() - int'(infl), 32'd2);
    check("pre_reset_midburst", {31'b0, bcnt != 0}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_read_en", {31'b0, read_en}, 32'd0);
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_last", {31'b0, m_last}, 32'd0);
    check("rst_m_data", {24'b0, m_data}, 32'd0);
    check("rst_beat_total", {16'b0, beat_total}, 32'd0);
    check("rst_idle", {31'b0, idle}, 32'd1);
    model_reset();
    @(negedge read_clk);
    step();
    reset = 1'b1;
    step();
    m_ready = 1'b1;
    drain(40, 1'b1);

    // beat_total wraps at 16 bits.
    enable = 1'b0;
    do_reset();
    for (int i = 0; i < 65537; i++) fifo.push_back(DW'(i));
    enable = 1'b1; m_ready = 1'b1;
    drain(65600, 1'b1);
    check("total_wrap", {16'b0, beat_total}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
